// File: rtl/plab5_mcore_dma_checker_multi.sv
// Multi-requester DMA security checker: round-robin arbitration, level check, DMA handoff, ack timeout.
// Optional deny counter enabled by defining PLAB5_MCORE_DMA_CHECKER_DENY_CNT_EN.
module plab5_mcore_dma_checker_multi #(
  parameter int unsigned p_num_req     = 4,
  parameter int unsigned p_addr_nbits  = 32,
  parameter int unsigned p_ctrl_nbits  = 40,
  parameter int unsigned p_rctrl_nbits = 8,
  parameter int unsigned p_lvl_nbits   = 2,
  parameter int unsigned p_timeout     = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [p_num_req-1:0]                req_val,
  output logic [p_num_req-1:0]                req_rdy,
  input  logic [p_num_req*p_lvl_nbits-1:0]    req_domain,
  input  logic [p_num_req*p_addr_nbits-1:0]   req_src_addr,
  input  logic [p_num_req*p_addr_nbits-1:0]   req_dest_addr,
  input  logic [p_num_req*p_ctrl_nbits-1:0]   req_ctrl,
  output logic [p_num_req-1:0]                resp_val,
  input  logic [p_num_req-1:0]                resp_rdy,
  output logic                                resp_deny,
  output logic                                resp_timeout,
  output logic [p_rctrl_nbits-1:0]            resp_ctrl,
  output logic                                dma_val,
  input  logic                                dma_rdy,
  output logic [p_lvl_nbits-1:0]              dma_domain,
  output logic [p_addr_nbits-1:0]             dma_src_addr,
  output logic [p_addr_nbits-1:0]             dma_dest_addr,
  output logic [p_ctrl_nbits-1:0]             dma_ctrl,
  input  logic                                dma_ack,
  input  logic [p_rctrl_nbits-1:0]            dma_resp_ctrl,
  input  logic                                cfg_val,
  input  logic [p_lvl_nbits-1:0]              cfg_domain,
  input  logic [p_lvl_nbits-1:0]              cfg_level,
  output logic                                cfg_err
`ifdef PLAB5_MCORE_DMA_CHECKER_DENY_CNT_EN
  ,
  input  logic                                deny_cnt_clr,
  output logic [15:0]                         deny_cnt
`endif
);

  localparam int unsigned CW = (p_num_req > 1) ? $clog2(p_num_req) : 1;
  localparam int unsigned TW = (p_timeout > 2) ? $clog2(p_timeout) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT, RESP} state_t;

  state_t                   state, state_nx;
  logic [CW-1:0]            rr_ptr, ch_r, grant_idx, cand_idx;
  logic                     grant_found;
  logic [p_lvl_nbits-1:0]   dom_r, sec_level;
  logic [p_addr_nbits-1:0]  src_r, dest_r;
  logic [p_ctrl_nbits-1:0]  ctrl_r;
  logic [p_rctrl_nbits-1:0] rctrl_r;
  logic                     deny_r, tmo_r;
  logic [TW-1:0]            timer;
  logic                     timer_last;

  assign timer_last = (timer == TW'(p_timeout - 1));

  // First requester strictly after rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int unsigned i = 1; i <= p_num_req; i++) begin
      cand_idx = CW'((32'(rr_ptr) + i) % p_num_req);
      if (!grant_found && req_val[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    req_rdy       = '0;
    resp_val      = '0;
    resp_deny     = 1'b0;
    resp_timeout  = 1'b0;
    resp_ctrl     = '0;
    dma_val       = 1'b0;
    dma_domain    = '0;
    dma_src_addr  = '0;
    dma_dest_addr = '0;
    dma_ctrl      = '0;
    case (state)
      IDLE: begin
        if (grant_found && !reset) begin
          req_rdy[grant_idx] = 1'b1;
          state_nx           = CHECK;
        end
      end
      CHECK: state_nx = (dom_r >= sec_level) ? REQ : RESP;
      REQ: begin
        dma_val       = 1'b1;
        dma_domain    = dom_r;
        dma_src_addr  = src_r;
        dma_dest_addr = dest_r;
        dma_ctrl      = ctrl_r;
        if (dma_rdy) state_nx = WAIT;
      end
      WAIT: begin
        if (dma_ack || timer_last) state_nx = RESP;
      end
      RESP: begin
        resp_val[ch_r] = 1'b1;
        resp_deny      = deny_r;
        resp_timeout   = tmo_r;
        resp_ctrl      = deny_r ? '0 : rctrl_r;
        if (resp_rdy[ch_r]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      ch_r    <= '0;
      dom_r   <= '0;
      src_r   <= '0;
      dest_r  <= '0;
      ctrl_r  <= '0;
      rctrl_r <= '0;
      deny_r  <= 1'b0;
      tmo_r   <= 1'b0;
      timer   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (grant_found) begin
            rr_ptr  <= grant_idx;
            ch_r    <= grant_idx;
            dom_r   <= req_domain[grant_idx*p_lvl_nbits +: p_lvl_nbits];
            src_r   <= req_src_addr[grant_idx*p_addr_nbits +: p_addr_nbits];
            dest_r  <= req_dest_addr[grant_idx*p_addr_nbits +: p_addr_nbits];
            ctrl_r  <= req_ctrl[grant_idx*p_ctrl_nbits +: p_ctrl_nbits];
            rctrl_r <= '0;
            deny_r  <= 1'b0;
            tmo_r   <= 1'b0;
          end
        end
        CHECK: begin
          if (dom_r < sec_level) deny_r <= 1'b1;
        end
        REQ: begin
          if (dma_rdy) timer <= '0;
        end
        WAIT: begin
          // An ack coinciding with expiry takes priority over the timeout.
          if (dma_ack) begin
            rctrl_r <= dma_resp_ctrl;
          end else if (timer_last) begin
            deny_r <= 1'b1;
            tmo_r  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_level <= '1;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_val && (cfg_domain != '1);
      if (cfg_val && (cfg_domain == '1)) sec_level <= cfg_level;
    end
  end

`ifdef PLAB5_MCORE_DMA_CHECKER_DENY_CNT_EN
  logic deny_issue;
  assign deny_issue = ((state == CHECK) && (dom_r < sec_level)) ||
                      ((state == WAIT) && !dma_ack && timer_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deny_cnt <= '0;
    end else if (deny_cnt_clr) begin
      deny_cnt <= '0;
    end else if (deny_issue && (deny_cnt != '1)) begin
      deny_cnt <= deny_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_plab5_mcore_dma_checker_multi.sv
// Randomised transaction-level bench for plab5_mcore_dma_checker_multi with a behavioural arbiter/level model.
module tb_plab5_mcore_dma_checker_multi;

  localparam int N = 4;
  localparam int A = 32;
  localparam int C = 40;
  localparam int R = 8;
  localparam int L = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_val, req_rdy, resp_val, resp_rdy;
  logic [N*L-1:0]   req_domain;
  logic [N*A-1:0]   req_src_addr, req_dest_addr;
  logic [N*C-1:0]   req_ctrl;
  logic             resp_deny, resp_timeout;
  logic [R-1:0]     resp_ctrl, dma_resp_ctrl;
  logic             dma_val, dma_rdy, dma_ack;
  logic [L-1:0]     dma_domain, cfg_domain, cfg_level;
  logic [A-1:0]     dma_src_addr, dma_dest_addr;
  logic [C-1:0]     dma_ctrl;
  logic             cfg_val, cfg_err;

  int n_checks = 0;
  int n_pass   = 0;
  int m_rr     = 0;
  int m_level  = 3;

  always #5 clk = ~clk;

  plab5_mcore_dma_checker_multi #(
    .p_num_req(N), .p_addr_nbits(A), .p_ctrl_nbits(C),
    .p_rctrl_nbits(R), .p_lvl_nbits(L), .p_timeout(64)
  ) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_domain(req_domain),
    .req_src_addr(req_src_addr), .req_dest_addr(req_dest_addr), .req_ctrl(req_ctrl),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_deny(resp_deny),
    .resp_timeout(resp_timeout), .resp_ctrl(resp_ctrl),
    .dma_val(dma_val), .dma_rdy(dma_rdy), .dma_domain(dma_domain),
    .dma_src_addr(dma_src_addr), .dma_dest_addr(dma_dest_addr), .dma_ctrl(dma_ctrl),
    .dma_ack(dma_ack), .dma_resp_ctrl(dma_resp_ctrl),
    .cfg_val(cfg_val), .cfg_domain(cfg_domain), .cfg_level(cfg_level), .cfg_err(cfg_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first requester after the last granted channel.
  function automatic int model_grant(input logic [N-1:0] mask);
    for (int off = 1; off <= N; off++) begin
      int c;
      c = (m_rr + off) % N;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic scramble_inputs;
    for (int ch = 0; ch < N; ch++) begin
      req_src_addr[ch*A +: A]  = $urandom;
      req_dest_addr[ch*A +: A] = $urandom;
      req_ctrl[ch*C +: C]      = {8'($urandom), 32'($urandom)};
    end
    req_domain = N*L'($urandom);
  endtask

  task automatic do_cfg(input logic [1:0] dom, input logic [1:0] lvl);
    cfg_val = 1'b1; cfg_domain = dom; cfg_level = lvl;
    tick;
    cfg_val = 1'b0; cfg_domain = 2'($urandom); cfg_level = 2'($urandom);
    @(negedge clk);
    check_eq("cfg_err", 64'(cfg_err), 64'(dom != 2'd3));
    if (dom == 2'd3) m_level = int'(lvl);
    tick;
    @(negedge clk);
    check_eq("cfg_err_pulse", 64'(cfg_err), 64'd0);
    tick;
  endtask

  // Entered and left just after a clock edge with the DUT idle.
  task automatic run_txn(input logic [N-1:0] mask, input logic [N*L-1:0] doms,
                         input int stall, input int ack_k, input int rstall);
    int g, last;
    logic [L-1:0] dom;
    logic [A-1:0] sa, da;
    logic [C-1:0] ct;
    logic [R-1:0] rc;
    logic [N-1:0] oh;
    bit deny, tmo;
    rc = '0; tmo = 0;
    scramble_inputs();
    req_val = mask; req_domain = doms;
    g   = model_grant(mask);
    oh  = N'(1) << g;
    dom = doms[g*L +: L];
    sa  = req_src_addr[g*A +: A];
    da  = req_dest_addr[g*A +: A];
    ct  = req_ctrl[g*C +: C];
    @(negedge clk);
    check_eq("req_rdy_grant", 64'(req_rdy), 64'(oh));
    tick;
    m_rr = g;
    scramble_inputs();
    @(negedge clk);
    check_eq("check_req_rdy", 64'(req_rdy), 64'd0);
    check_eq("check_dma_val", 64'(dma_val), 64'd0);
    check_eq("check_resp_val", 64'(resp_val), 64'd0);
    tick;
    deny = (int'(dom) < m_level);
    if (!deny) begin
      for (int s = 0; s <= stall; s++) begin
        dma_rdy = (s == stall);
        @(negedge clk);
        check_eq("dma_val", 64'(dma_val), 64'd1);
        check_eq("dma_domain", 64'(dma_domain), 64'(dom));
        check_eq("dma_src", 64'(dma_src_addr), 64'(sa));
        check_eq("dma_dest", 64'(dma_dest_addr), 64'(da));
        check_eq("dma_ctrl", 64'(dma_ctrl), 64'(ct));
        check_eq("req_busy_rdy", 64'(req_rdy), 64'd0);
        tick;
      end
      dma_rdy = 1'b0;
      last = (ack_k < 64) ? ack_k : 63;
      rc   = R'($urandom);
      for (int j = 0; j <= last; j++) begin
        dma_ack       = (j == ack_k);
        dma_resp_ctrl = (j == ack_k) ? rc : R'($urandom);
        @(negedge clk);
        check_eq("wait_resp_val", 64'(resp_val), 64'd0);
        check_eq("wait_dma_val", 64'(dma_val), 64'd0);
        tick;
      end
      dma_ack = 1'b0;
      if (ack_k == 64) begin
        dma_ack = 1'b1;
        dma_resp_ctrl = R'($urandom);
      end
      tmo = (ack_k > 63);
    end
    for (int r = 0; r <= rstall; r++) begin
      resp_rdy    = N'($urandom);
      resp_rdy[g] = (r == rstall);
      @(negedge clk);
      check_eq("resp_val", 64'(resp_val), 64'(oh));
      check_eq("resp_deny", 64'(resp_deny), 64'(deny || tmo));
      check_eq("resp_timeout", 64'(resp_timeout), 64'(tmo));
      check_eq("resp_ctrl", 64'(resp_ctrl), (deny || tmo) ? 64'd0 : 64'(rc));
      check_eq("resp_dma_val", 64'(dma_val), 64'd0);
      tick;
      dma_ack = 1'b0;
    end
    resp_rdy = '0;
    req_val  = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mask, stall, ack_k, rsel;
    reset = 1'b1;
    req_val = '0; resp_rdy = '0; dma_rdy = 1'b0; dma_ack = 1'b0; dma_resp_ctrl = '0;
    cfg_val = 1'b0; cfg_domain = '0; cfg_level = '0;
    scramble_inputs();
    repeat (2) @(negedge clk);
    req_val = '1;
    #1;
    check_eq("rst_req_rdy", 64'(req_rdy), 64'd0);
    check_eq("rst_resp_val", 64'(resp_val), 64'd0);
    check_eq("rst_dma_val", 64'(dma_val), 64'd0);
    check_eq("rst_cfg_err", 64'(cfg_err), 64'd0);
    check_eq("rst_resp_deny", 64'(resp_deny | resp_timeout), 64'd0);
    tick;
    req_val = '0;
    reset = 1'b0;
    m_rr = 0; m_level = 3;

    // Directed scenarios
    run_txn(4'b0010, 8'hFF, 0, 3, 0);
    run_txn(4'b0001, 8'b11_11_11_01, 0, 0, 1);
    for (int k = 0; k < 5; k++) run_txn(4'b1111, 8'hFF, 0, 0, 0);
    do_cfg(2'd2, 2'd1);
    run_txn(4'b0001, 8'b11_11_11_01, 0, 0, 0);
    do_cfg(2'd3, 2'd1);
    run_txn(4'b0001, 8'b11_11_11_01, 1, 2, 0);
    run_txn(4'b0100, 8'hFF, 0, 1000, 0);
    run_txn(4'b0100, 8'hFF, 0, 63, 0);
    run_txn(4'b1000, 8'hFF, 2, 64, 1);
    run_txn(4'b1001, 8'b00_11_11_11, 0, 62, 0);

    // Randomised traffic with interleaved level writes
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 9) < 3) do_cfg(2'($urandom), 2'($urandom));
      mask  = $urandom_range(1, 15);
      stall = $urandom_range(0, 2);
      rsel  = $urandom_range(0, 19);
      if (rsel < 15)       ack_k = $urandom_range(0, 5);
      else if (rsel == 15) ack_k = 63;
      else if (rsel == 16) ack_k = 64;
      else if (rsel == 17) ack_k = 1000;
      else                 ack_k = 62;
      run_txn(N'(mask), N*L'($urandom), stall, ack_k, $urandom_range(0, 2));
    end

    // Reset in the middle of WAIT
    do_cfg(2'd3, 2'd0);
    req_val = 4'b0001;
    @(negedge clk);
    check_eq("rw_grant", 64'(req_rdy), 64'd1);
    tick;
    req_val = '0;
    tick;
    dma_rdy = 1'b1;
    @(negedge clk);
    check_eq("rw_dma_val", 64'(dma_val), 64'd1);
    tick;
    dma_rdy = 1'b0;
    @(negedge clk);
    req_val = '1;
    #2 reset = 1'b1;
    #1;
    check_eq("rw_req_rdy", 64'(req_rdy), 64'd0);
    check_eq("rw_resp_val", 64'(resp_val), 64'd0);
    check_eq("rw_dma_val0", 64'(dma_val), 64'd0);
    check_eq("rw_resp_deny", 64'(resp_deny | resp_timeout), 64'd0);
    dma_ack = 1'b1;
    tick;
    dma_ack = 1'b0;
    req_val = '0;
    reset = 1'b0;
    m_rr = 0; m_level = 3;
    @(negedge clk);
    check_eq("rw_no_resp", 64'(resp_val), 64'd0);
    tick;
    run_txn(4'b0001, 8'hFF, 0, 1, 0);
    run_txn(4'b1111, 8'hFF, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/plab5_mcore_dma_checker_multi.md
Name: plab5_mcore_dma_checker_multi

Overview:
- Parametrised successor to the single-port DMA security checker.
- Arbitrates among p_num_req requesters (cores, debug, NoC bridges) with round-robin priority and checks each request's security domain against a programmable level register.
- Forwards permitted requests to the DMA controller and returns ack or deny to the originator.
- Adds a programmable security level, a config port writable only from the top domain, and a DMA-ack timeout.

Parameters:
p_num_req, 4, number of requester channels (2..8)
p_addr_nbits, 32, source/destination address width
p_ctrl_nbits, 40, request control field width (memory-message control bits)
p_rctrl_nbits, 8, response control field width
p_lvl_nbits, 2, security level width; level 2^p_lvl_nbits-1 is the top (secure) domain
p_timeout, 64, cycles allowed in WAIT before forced deny

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
req_val  input  N  per-channel request valid
req_rdy  output  N  per-channel ready; at most one bit set
req_domain  input  N*p_lvl_nbits  per-channel security level
req_src_addr  input  N*p_addr_nbits  per-channel DMA source address
req_dest_addr  input  N*p_addr_nbits  per-channel DMA destination address
req_ctrl  input  N*p_ctrl_nbits  per-channel control field
resp_val  output  N  one-hot response valid
resp_rdy  input  N  per-channel response ready
resp_deny  output  1  1 = rejected (level or timeout)
resp_timeout  output  1  1 = deny caused by timeout
resp_ctrl  output  p_rctrl_nbits  DMA response control (0 when denied)
dma_val  output  1  request to DMA controller
dma_rdy  input  1  DMA controller ready
dma_domain  output  p_lvl_nbits  domain of forwarded request
dma_src_addr  output  p_addr_nbits  forwarded source address
dma_dest_addr  output  p_addr_nbits  forwarded destination address
dma_ctrl  output  p_ctrl_nbits  forwarded control
dma_ack  input  1  DMA completion pulse
dma_resp_ctrl  input  p_rctrl_nbits  DMA response control
cfg_val  input  1  write security level
cfg_domain  input  p_lvl_nbits  writer's domain
cfg_level  input  p_lvl_nbits  new level
cfg_err  output  1  one-cycle pulse: write rejected

Behaviour:
- Reset (async, immediate): state IDLE, sec_level = all ones, rr_ptr = 0, timer = 0. All outputs 0, including req_rdy and resp_val. A reset mid-transaction abandons the transaction; no response is issued.
- States: IDLE, CHECK, REQ, WAIT, RESP.
- IDLE:
  - grant = first channel with req_val set, searching from rr_ptr+1 upward with wrap.
  - req_rdy[grant] = 1 combinationally.
  - On accept, latch channel index, domain, addresses and ctrl, then go to CHECK.
  - rr_ptr = grant on accept.
  - No request: stay in IDLE with req_rdy = 0.
- CHECK (1 cycle): latched domain >= sec_level -> REQ; otherwise -> RESP with deny = 1.
- REQ: dma_val = 1 with latched fields; hold until dma_rdy, then -> WAIT and clear timer. No field changes while dma_val is held.
- WAIT:
  - dma_ack -> RESP, capturing dma_resp_ctrl.
  - Otherwise timer increments; at timer == p_timeout-1 without ack -> RESP with deny = 1 and timeout = 1.
  - A dma_ack arriving in the same cycle as expiry wins (not a timeout).
  - A late dma_ack outside WAIT is ignored.
- RESP:
  - resp_val[ch] = 1; deny, timeout and ctrl are held.
  - Leave to IDLE when resp_rdy[ch] = 1.
- Latency, no backpressure: permit path = accept + 1 (CHECK) + 1 (REQ) + DMA latency + 1 (RESP). Deny path = accept, CHECK, RESP, i.e. resp_val 2 cycles after accept.
- Config:
  - A write takes effect the next cycle when cfg_val = 1 and cfg_domain = all ones.
  - Any other cfg_val = 1 is dropped and pulses cfg_err the next cycle.
  - Writes are legal in any state. CHECK uses the sec_level value current in that cycle.
- Only one transaction is outstanding at a time; other channels see req_rdy = 0.

Optional Feature:
PLAB5_MCORE_DMA_CHECKER_DENY_CNT_EN:
- Defined: adds output deny_cnt [15:0] and input deny_cnt_clr.
- deny_cnt increments once per response issued with deny = 1 (level or timeout) and saturates at 16'hFFFF.
- deny_cnt_clr zeroes the count; clear wins over a simultaneous increment. Reset value is 0.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- Channel 1, domain 3, sec_level 3, dma_ack 4 cycles after dma_rdy -> dma_val once with channel-1 fields; resp_val = 4'b0010, deny = 0, resp_ctrl = dma_resp_ctrl.
- Channel 0, domain 1, sec_level 3 -> no dma_val; resp_val[0] 2 cycles after accept; deny = 1, timeout = 0.
- All 4 channels valid continuously, immediate ack -> grants in order 1, 2, 3, 0, 1; no channel granted twice in succession.
- cfg write level 1 from domain 2 -> cfg_err pulse, sec_level stays 3. Same write from domain 3 -> a domain-1 request is then permitted.
- No dma_ack, p_timeout = 64 -> resp_val exactly 64 cycles after WAIT entry with deny = 1, timeout = 1. Ack on cycle 64 -> deny = 0.
- Assert reset while in WAIT -> all outputs 0 immediately; after release, a new request on channel 0 is granted first (rr_ptr = 0).
